// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between CPU and IO.
// Fixed CPU priority, with a starvation limit that forces an IO grant.
module mem_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_SIZE    = 200,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_ACK,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_ERR,
    input  logic              IO_REQ,
    input  logic              IO_WE,
    input  logic [ADDR_W-1:0] IO_ADDR,
    input  logic [DATA_W-1:0] IO_WDATA,
    output logic              IO_ACK,
    output logic [DATA_W-1:0] IO_RDATA,
    output logic              IO_ERR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE_CPU,
        S_SERVE_IO,
        S_ACK_CPU,
        S_ACK_IO
    } state_t;

    localparam logic [ADDR_W:0] LIMIT   = (ADDR_W+1)'(MEM_SIZE);
    localparam logic [3:0]      MAX_RUN = 4'(MAX_CPU_RUN);

    state_t              state_q, state_d;
    logic [3:0]          starve_q, starve_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                we_q, we_d;
    logic                oor_q, oor_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                io_ack_q, io_ack_d;
    logic                io_err_q, io_err_d;
    logic [DATA_W-1:0]   io_rdata_q, io_rdata_d;

    logic                cpu_win;
    logic                io_win;
    logic                cpu_inr;
    logic                io_inr;

    assign cpu_inr = ({1'b0, CPU_ADDR} < LIMIT);
    assign io_inr  = ({1'b0, IO_ADDR} < LIMIT);

    // CPU loses a contested slot only once it has used up its run
    assign cpu_win = CPU_REQ && !(IO_REQ && starve_q == MAX_RUN);
    assign io_win  = IO_REQ && !cpu_win;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        we_d        = we_q;
        oor_d       = oor_q;
        cpu_ack_d   = cpu_ack_q;
        cpu_err_d   = cpu_err_q;
        cpu_rdata_d = cpu_rdata_q;
        io_ack_d    = io_ack_q;
        io_err_d    = io_err_q;
        io_rdata_d  = io_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (!IO_REQ) begin
                    starve_d = 4'd0;
                end
                unique case (1'b1)
                    cpu_win: begin
                        state_d     = S_SERVE_CPU;
                        mem_addr_d  = CPU_ADDR;
                        mem_wdata_d = CPU_WDATA;
                        mem_we_d    = CPU_WE && cpu_inr;
                        we_d        = CPU_WE;
                        oor_d       = !cpu_inr;
                        if (IO_REQ && starve_q != MAX_RUN) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                    io_win: begin
                        state_d     = S_SERVE_IO;
                        mem_addr_d  = IO_ADDR;
                        mem_wdata_d = IO_WDATA;
                        mem_we_d    = IO_WE && io_inr;
                        we_d        = IO_WE;
                        oor_d       = !io_inr;
                        starve_d    = 4'd0;
                    end
                    default: ;
                endcase
            end
            S_SERVE_CPU: begin
                state_d   = S_ACK_CPU;
                mem_we_d  = 1'b0;
                cpu_ack_d = 1'b1;
                cpu_err_d = oor_q;
                if (!we_q) begin
                    cpu_rdata_d = oor_q ? '0 : MEM_RDATA;
                end
            end
            S_SERVE_IO: begin
                state_d  = S_ACK_IO;
                mem_we_d = 1'b0;
                io_ack_d = 1'b1;
                io_err_d = oor_q;
                if (!we_q) begin
                    io_rdata_d = oor_q ? '0 : MEM_RDATA;
                end
            end
            S_ACK_CPU: begin
                state_d   = S_IDLE;
                cpu_ack_d = 1'b0;
                cpu_err_d = 1'b0;
            end
            S_ACK_IO: begin
                state_d  = S_IDLE;
                io_ack_d = 1'b0;
                io_err_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            starve_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            io_ack_q    <= 1'b0;
            io_err_q    <= 1'b0;
            io_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_ack_q    <= io_ack_d;
            io_err_q    <= io_err_d;
            io_rdata_q  <= io_rdata_d;
        end
    end

    assign CPU_ACK   = cpu_ack_q;
    assign CPU_ERR   = cpu_err_q;
    assign CPU_RDATA = cpu_rdata_q;
    assign IO_ACK    = io_ack_q;
    assign IO_ERR    = io_err_q;
    assign IO_RDATA  = io_rdata_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_WE    = mem_we_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model, per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int MSIZE = 200;
    localparam int MAXR  = 4;

    logic        CLK = 0;
    logic        RST = 1;
    logic        CPU_REQ = 0, CPU_WE = 0;
    logic [15:0] CPU_ADDR = 0, CPU_WDATA = 0;
    logic        CPU_ACK, CPU_ERR;
    logic [15:0] CPU_RDATA;
    logic        IO_REQ = 0, IO_WE = 0;
    logic [15:0] IO_ADDR = 0, IO_WDATA = 0;
    logic        IO_ACK, IO_ERR;
    logic [15:0] IO_RDATA;
    logic [15:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic        MEM_WE, BUSY;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_SIZE(MSIZE), .MAX_CPU_RUN(MAXR)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR),
        .CPU_WDATA(CPU_WDATA), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
        .CPU_ERR(CPU_ERR),
        .IO_REQ(IO_REQ), .IO_WE(IO_WE), .IO_ADDR(IO_ADDR),
        .IO_WDATA(IO_WDATA), .IO_ACK(IO_ACK), .IO_RDATA(IO_RDATA),
        .IO_ERR(IO_ERR),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
        .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 0;
    int we_cnt = 0;
    logic [15:0] last_we_addr = 0;

    // memory array: combinational read, falling-edge write
    logic [15:0] mem [0:MSIZE-1];
    assign MEM_RDATA = (MEM_ADDR < 16'(MSIZE)) ? mem[MEM_ADDR] : 16'h0;
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1 && MEM_ADDR < 16'(MSIZE)) mem[MEM_ADDR] <= MEM_WDATA;
        if (MEM_WE === 1'b1) begin
            we_cnt++;
            last_we_addr = MEM_ADDR;
        end
    end

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [15:0] ref_mem [0:MSIZE-1];
    int          left = 0;
    int          starve = 0;
    bit          t_io, t_we, t_oor;
    logic [15:0] t_rd;
    logic [15:0] e_maddr = 0, e_mwdata = 0, e_crd = 0, e_ird = 0;
    logic        e_mwe = 0, e_cack = 0, e_iack = 0;
    logic        e_cerr = 0, e_ierr = 0, e_busy = 0;

    always @(posedge CLK) begin
        bit pick_io, pick_cpu;
        logic [15:0] a, wd;
        bit w;
        if (RST) begin
            e_maddr = 0; e_mwdata = 0; e_crd = 0; e_ird = 0;
            e_mwe = 0; e_cack = 0; e_iack = 0;
            e_cerr = 0; e_ierr = 0; e_busy = 0;
            left = 0; starve = 0;
        end else if (left == 2) begin
            e_mwe = 0;
            if (t_io) begin
                e_iack = 1; e_ierr = t_oor;
                if (!t_we) e_ird = t_rd;
            end else begin
                e_cack = 1; e_cerr = t_oor;
                if (!t_we) e_crd = t_rd;
            end
            left = 1;
        end else if (left == 1) begin
            e_cack = 0; e_iack = 0; e_cerr = 0; e_ierr = 0;
            e_busy = 0;
            left = 0;
        end else begin
            pick_io  = IO_REQ && (!CPU_REQ || starve >= MAXR);
            pick_cpu = CPU_REQ && !pick_io;
            if (pick_io || pick_cpu) begin
                a  = pick_io ? IO_ADDR : CPU_ADDR;
                wd = pick_io ? IO_WDATA : CPU_WDATA;
                w  = pick_io ? IO_WE : CPU_WE;
                t_io  = pick_io;
                t_we  = w;
                t_oor = (a >= 16'(MSIZE));
                t_rd  = t_oor ? 16'h0 : ref_mem[a];
                if (w && !t_oor) ref_mem[a] = wd;
                e_maddr = a; e_mwdata = wd; e_mwe = w && !t_oor;
                e_busy = 1;
                left = 2;
            end
            if (pick_io || !IO_REQ) starve = 0;
            else if (pick_cpu) starve++;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("MEM_ADDR", 32'(MEM_ADDR), 32'(e_maddr));
            chk("MEM_WDATA", 32'(MEM_WDATA), 32'(e_mwdata));
            chk("MEM_WE", 32'(MEM_WE), 32'(e_mwe));
            chk("BUSY", 32'(BUSY), 32'(e_busy));
            chk("CPU_ACK", 32'(CPU_ACK), 32'(e_cack));
            chk("CPU_ERR", 32'(CPU_ERR), 32'(e_cerr));
            chk("CPU_RDATA", 32'(CPU_RDATA), 32'(e_crd));
            chk("IO_ACK", 32'(IO_ACK), 32'(e_iack));
            chk("IO_ERR", 32'(IO_ERR), 32'(e_ierr));
            chk("IO_RDATA", 32'(IO_RDATA), 32'(e_ird));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic access(input bit io, input logic we, input logic [15:0] a,
                          input logic [15:0] d, output int lat);
        @(negedge CLK);
        if (io) begin
            IO_WE = we; IO_ADDR = a; IO_WDATA = d; IO_REQ = 1;
        end else begin
            CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d; CPU_REQ = 1;
        end
        lat = 0;
        while ((io ? IO_ACK : CPU_ACK) !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        if (lat >= 20) begin
            checks++; errors++;
            $display("FAIL ack_timeout: io=%0d got no ACK within 20 cycles", io);
        end
        if (io) IO_REQ = 0;
        else CPU_REQ = 0;
    endtask

    string seq;
    int    ack_cyc[$];

    task automatic run_both(input int n);
        seq = "";
        ack_cyc.delete();
        @(negedge CLK);
        CPU_WE = 0; CPU_ADDR = 16'd10; IO_WE = 0; IO_ADDR = 16'd11;
        CPU_REQ = 1; IO_REQ = 1;
        for (int k = 0; k < n * 3 + 10 && seq.len() < n; k++) begin
            @(negedge CLK);
            if (CPU_ACK === 1'b1) begin seq = {seq, "C"}; ack_cyc.push_back(cyc); end
            if (IO_ACK === 1'b1) begin seq = {seq, "I"}; ack_cyc.push_back(cyc); end
        end
        CPU_REQ = 0; IO_REQ = 0;
    endtask

    task automatic chk_seq(input string nm, input string exp);
        checks++;
        if (seq != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", nm, seq, exp);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int lat, wc, tc, ti;
        for (int i = 0; i < MSIZE; i++) begin
            mem[i] = 16'hA000 + 16'(i);
            ref_mem[i] = 16'hA000 + 16'(i);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_en = 1;
        chk("reset_busy", 32'(BUSY), 0);
        chk("reset_cpu_ack", 32'(CPU_ACK), 0);
        chk("reset_mem_we", 32'(MEM_WE), 0);
        chk("reset_io_rdata", 32'(IO_RDATA), 0);
        RST = 0;

        // write then read back
        wc = we_cnt;
        access(0, 1, 16'd5, 16'h1234, lat);
        chk("wr_latency", 32'(lat), 2);
        chk("wr_we_pulses", 32'(we_cnt - wc), 1);
        chk("wr_we_addr", 32'(last_we_addr), 5);
        wc = we_cnt;
        access(0, 0, 16'd5, 16'h0, lat);
        chk("rd_latency", 32'(lat), 2);
        chk("rd_data", 32'(CPU_RDATA), 32'h1234);
        chk("rd_err", 32'(CPU_ERR), 0);
        chk("rd_no_we", 32'(we_cnt - wc), 0);

        // continuous contention: 4 CPU then 1 IO
        run_both(15);
        chk_seq("grant_seq", "CCCCICCCCICCCCI");
        for (int i = 1; i < ack_cyc.size(); i++)
            chk("ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 3);
        repeat (2) @(negedge CLK);

        // simultaneous writes to the same word
        fork
            begin
                int l1;
                access(0, 1, 16'd7, 16'hAAAA, l1);
                tc = cyc;
            end
            begin
                int l2;
                access(1, 1, 16'd7, 16'h5555, l2);
                ti = cyc;
            end
        join
        chk("cpu_before_io", 32'(ti - tc), 3);
        access(0, 0, 16'd7, 16'h0, lat);
        chk("rd7_data", 32'(CPU_RDATA), 32'h5555);

        // out-of-range IO read
        chk("io_rdata_prior", 32'(IO_RDATA), 32'hA00B);
        wc = we_cnt;
        access(1, 0, 16'd200, 16'h0, lat);
        chk("oor_rdata", 32'(IO_RDATA), 0);
        chk("oor_err", 32'(IO_ERR), 1);
        chk("oor_latency", 32'(lat), 2);
        chk("oor_no_we", 32'(we_cnt - wc), 0);
        chk("oor_mem199", 32'(mem[199]), 32'hA0C7);

        // IO raised then withdrawn: counter must restart from 0
        run_both(3);
        chk_seq("withdrawn_io_seq", "CCC");
        repeat (2) @(negedge CLK);
        run_both(5);
        chk_seq("after_withdraw_seq", "CCCCI");
        repeat (2) @(negedge CLK);

        // reset during SERVE_IO of a write
        @(negedge CLK);
        IO_WE = 1; IO_ADDR = 16'd3; IO_WDATA = 16'h00FF; IO_REQ = 1;
        @(negedge CLK);
        chk("rst_serve_we", 32'(MEM_WE), 1);
        chk("rst_serve_addr", 32'(MEM_ADDR), 3);
        RST = 1;
        @(negedge CLK);
        chk("rst_io_ack", 32'(IO_ACK), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 0);
        chk("rst_cpu_rdata", 32'(CPU_RDATA), 0);
        RST = 0; IO_REQ = 0; IO_WE = 0;
        @(negedge CLK);
        chk("rst_mem3", 32'(mem[3]), 32'h00FF);
        access(0, 0, 16'd3, 16'h0, lat);
        chk("rd3_data", 32'(CPU_RDATA), 32'h00FF);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 16-bit main-memory port between two requesters: CPU and IO.
- Each requester uses a REQ/ACK handshake. The arbiter registers the winning request, drives the memory port for exactly one cycle, then returns read data and an ACK pulse.
- Arbitration is fixed CPU priority, with a starvation limit that forces an IO grant.
- Sits between the CPU load/store stage, the IO controller and the main memory array. The memory reads combinationally and writes on the falling CLK edge.

Parameters:
- ADDR_W, 16, address width of requester and memory ports.
- DATA_W, 16, data width.
- MEM_SIZE, 200, number of valid words; addresses >= MEM_SIZE are out of range.
- MAX_CPU_RUN, 4, maximum consecutive CPU grants while IO_REQ is pending; 1..15.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  synchronous active-high reset.
- CPU_REQ  in  1  CPU request; held with CPU_WE/ADDR/WDATA stable until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read.
- CPU_ADDR  in  ADDR_W  CPU word address.
- CPU_WDATA  in  DATA_W  CPU write data.
- CPU_ACK  out  1  one-cycle completion pulse.
- CPU_RDATA  out  DATA_W  read data; valid when CPU_ACK is high, held afterwards.
- CPU_ERR  out  1  pulses with CPU_ACK when the address was out of range.
- IO_REQ, IO_WE, IO_ADDR, IO_WDATA, IO_ACK, IO_RDATA, IO_ERR: identical set for the IO requester.
- MEM_ADDR  out  ADDR_W  registered memory address.
- MEM_WDATA  out  DATA_W  registered memory write data.
- MEM_WE  out  1  registered write enable; memory commits on the falling edge inside the cycle.
- MEM_RDATA  in  DATA_W  combinational memory read data.
- BUSY  out  1  high in every state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, starvation counter 0.
- States: IDLE, SERVE_CPU, SERVE_IO, ACK_CPU, ACK_IO.
- IDLE → SERVE_x on a rising edge when a request is present. On the same edge, MEM_ADDR/MEM_WDATA take the winner's ADDR/WDATA. MEM_WE = winner WE AND (ADDR < MEM_SIZE).
- SERVE_x lasts one cycle; the memory write happens on its falling edge.
  - At the end of SERVE_x: x_RDATA <= MEM_RDATA for an in-range read. x_RDATA <= 0 for an out-of-range read. x_RDATA is unchanged on a write.
  - x_ERR <= out-of-range, MEM_WE <= 0, x_ACK <= 1; next state ACK_x.
- ACK_x lasts one cycle: x_ACK = 1, then 0. Next state IDLE. Requests are not sampled in ACK_x, so the requester drops REQ during this cycle.
- Latency: REQ seen at edge n → memory access in cycle n..n+1 → ACK high in cycle n+1..n+2. Throughput is one access per 3 cycles.
- Arbitration in IDLE:
  - Only one REQ → that requester wins.
  - Both REQs → CPU wins unless the starvation counter equals MAX_CPU_RUN; then IO wins.
- Starvation counter:
  - Increments on each CPU grant made while IO_REQ = 1.
  - Clears on any IO grant, and on any IDLE edge where IO_REQ = 0.
  - Saturates at MAX_CPU_RUN.
- Out-of-range access:
  - MEM_WE is never asserted; MEM_ADDR is still driven.
  - Handshake timing is identical to a normal access.
- REQ dropped before grant: treated as withdrawn; no access.
- Changing ADDR/WDATA/WE while REQ is high before ACK is a requester error. The arbiter uses the values sampled at grant.
- Reset mid-operation:
  - RST sampled high at the rising edge that ends SERVE_x: the falling-edge write of that cycle has already committed, but ACK is not issued.
  - After reset: state IDLE, all outputs 0.

Test Plan:
- CPU write 0x1234 to addr 5, then CPU read addr 5 → MEM_WE high for exactly one cycle with MEM_ADDR = 5; CPU_ACK pulses 2 cycles after REQ; on the read ACK, CPU_RDATA = 0x1234 and CPU_ERR = 0.
- CPU_REQ and IO_REQ held continuously, MAX_CPU_RUN = 4 → grant sequence CPU, CPU, CPU, CPU, IO, repeating; each ACK is a single-cycle pulse; 3 cycles per access.
- Both requesters write addr 7 simultaneously (CPU 0xAAAA, IO 0x5555), then CPU reads 7 → CPU served first, IO second; read returns 0x5555.
- IO read at addr 200 (MEM_SIZE = 200) → MEM_WE stays 0, IO_RDATA = 0, IO_ERR = 1 together with IO_ACK; memory contents unchanged.
- RST asserted during SERVE_IO of a write of 0x00FF to addr 3 → no IO_ACK; all outputs 0 the next cycle; a subsequent CPU read of addr 3 returns 0x00FF.
- IO_REQ raised then dropped while a CPU access is in progress → IO is never granted; starvation counter is 0 afterwards.
